pipe_ctrl_seq: RTL and testbench
================================

PIPE_CTRL_SEQ -- requirements
Module: pipe_ctrl_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 id_valid  input  1  instruction in ID is valid.
REQ-004 id_ctrl  input  8  decoded control word (ctrl_t) from ID.
REQ-005 id_rs1, id_rs2, id_rd  input  5 each  ID source/destination register numbers.
REQ-006 br_taken  input  1  EX-stage branch resolved taken; honoured only when ex_valid and ex_ctrl.branch or ex_ctrl.uncond_br.
REQ-007 mem_ready  input  1  data memory completes the MEM-stage access this cycle.
REQ-008 ex_valid/ex_ctrl/ex_rd, mem_valid/mem_ctrl/mem_rd, wb_valid/wb_ctrl/wb_rd  output  1/8/5  registered per-stage control.
REQ-009 stall_id  output  1  hold PC and IF/ID this cycle (combinational).
REQ-010 flush_id  output  1  squash IF/ID contents this cycle (combinational).
REQ-011 mem_timeout  output  1  sticky: MEM wait exceeded 255 cycles.
REQ-012 lu_stall_cnt, flush_cnt, wait_cnt  output  16 each  saturating event counters.

Function
REQ-013 ctrl_t bit map: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [5] branch, [6] uncond_br, [7] set_flags.
REQ-014 freeze = mem_valid & (mem_ctrl.mem_read | mem_ctrl.mem_write) & ~mem_ready.
REQ-015 load_use = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != 31) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-016 take = br_taken & ex_valid & (ex_ctrl.branch | ex_ctrl.uncond_br).
REQ-017 Priority: freeze > take > load_use.
REQ-018 freeze: all stage registers hold; stall_id=1; flush_id=0; br_taken ignored (branch stays in EX, re-evaluated after freeze).
REQ-019 No freeze: WB<=MEM, MEM<=EX every cycle (one-cycle latency per stage; ID-to-WB = 3 cycles).
REQ-020 No freeze, take: EX<=bubble (valid=0, ctrl=0, rd=0); flush_id=1; stall_id=0.
REQ-021 No freeze, no take, load_use: EX<=bubble; stall_id=1; flush_id=0.
REQ-022 Otherwise: EX<={id_valid, id_valid?id_ctrl:0, id_valid?id_rd:0}; stall_id=0; flush_id=0.
REQ-023 FSM states RUN, MEM_WAIT; RUN->MEM_WAIT when freeze; MEM_WAIT->RUN when ~freeze; wait timer (8-bit) clears on entry to MEM_WAIT, increments each MEM_WAIT cycle.
REQ-024 Timer reaching 255 while in MEM_WAIT sets mem_timeout; mem_timeout clears only on reset; pipeline behaviour unchanged by timeout.
REQ-025 lu_stall_cnt +1 per REQ-021 cycle; flush_cnt +1 per REQ-020 cycle; wait_cnt +1 per freeze cycle; each saturates at 16'hFFFF.
REQ-026 A bubble never increments counters or asserts stall_id/flush_id by itself.

Reset
REQ-027 reset high at clk edge: all valid=0, ctrl=0, rd=0, counters=0, timer=0, state=RUN, mem_timeout=0.
REQ-028 While reset high, stall_id=0 and flush_id=0 regardless of inputs.
REQ-029 Reset mid-freeze or mid-stall discards all in-flight control; first post-reset cycle behaves as empty pipeline.

Structure
REQ-030 ctrl_t packed struct, XZR=5'd31, TIMEOUT=8'd255, state enum in pipe_ctrl_pkg.
REQ-031 One sub-module pipe_stage_reg (valid/ctrl/rd register with hold and bubble controls), instantiated three times.

Verification
REQ-032 reset 2 cycles, then ID ctrl=8'h11 rd=3 valid -> ex_ctrl=8'h11 next cycle, mem next, wb_ctrl=8'h11, wb_rd=3 third cycle.
REQ-033 EX load (ctrl=8'h0B, rd=5), ID rs1=5 -> stall_id=1 one cycle, EX bubble, lu_stall_cnt=1; same with rd=31 -> no stall.
REQ-034 EX branch ctrl=8'h20, br_taken=1, ID load_use also true -> flush_id=1, stall_id=0, flush_cnt=1.
REQ-035 MEM store, mem_ready=0 for 4 cycles -> stages hold, stall_id=1 4 cycles, wait_cnt=4, state back to RUN after ready.
REQ-036 mem_ready=0 for 300 cycles -> mem_timeout=1 after 255 MEM_WAIT cycles, stays 1 until reset; reset mid-wait -> all outputs zero.

Source files
------------

// File: rtl/pipe_ctrl_seq_pkg.sv
`default_nettype none
//==============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline control sequencer:
//               decoded control word, zero-register number, MEM wait timeout
//               and sequencer state encoding, plus small helper functions.
// Revision    : 1.0 - initial release
//==============================================================================
package pipe_ctrl_pkg;

    // Decoded control word; first field is the MSB (bit 7).
    typedef struct packed {
        logic set_flags;   // [7]
        logic uncond_br;   // [6]
        logic branch;      // [5]
        logic alu_src;     // [4]
        logic mem_to_reg;  // [3]
        logic mem_write;   // [2]
        logic mem_read;    // [1]
        logic reg_write;   // [0]
    } ctrl_t;

    // Register 31 reads as zero, so a load targeting it never creates a hazard.
    localparam logic [4:0] XZR     = 5'd31;
    localparam logic [7:0] TIMEOUT = 8'd255;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    function automatic logic is_mem_access(input ctrl_t c);
        return c.mem_read | c.mem_write;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_seq_if.sv
`default_nettype none
//==============================================================================
// Module      : pipe_ctrl_seq_if
// Description : Bundle of ID-stage inputs, branch/memory status inputs and the
//               per-stage control, hazard and statistics outputs of the
//               pipeline control sequencer.
//               master : drives ID/branch/memory inputs, observes outputs
//               slave  : the sequencer itself
// Revision    : 1.0 - initial release
//==============================================================================
interface pipe_ctrl_seq_if;
    import pipe_ctrl_pkg::*;

    // ID stage
    logic        id_valid;
    ctrl_t       id_ctrl;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    // EX / MEM status
    logic        br_taken;
    logic        mem_ready;
    // Registered per-stage control
    logic        ex_valid;
    ctrl_t       ex_ctrl;
    logic [4:0]  ex_rd;
    logic        mem_valid;
    ctrl_t       mem_ctrl;
    logic [4:0]  mem_rd;
    logic        wb_valid;
    ctrl_t       wb_ctrl;
    logic [4:0]  wb_rd;
    // Hazard control and status
    logic        stall_id;
    logic        flush_id;
    logic        mem_timeout;
    logic [15:0] lu_stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] wait_cnt;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, br_taken, mem_ready,
        input  ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd,
               wb_valid, wb_ctrl, wb_rd, stall_id, flush_id, mem_timeout,
               lu_stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, br_taken, mem_ready,
        output ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd,
               wb_valid, wb_ctrl, wb_rd, stall_id, flush_id, mem_timeout,
               lu_stall_cnt, flush_cnt, wait_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_seq_stage.sv
`default_nettype none
//==============================================================================
// Module      : pipe_stage_reg
// Description : One pipeline stage control register (valid / ctrl / rd).
//               Priority: reset > hold > bubble > load.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               i_hold            - keep current contents
//               i_bubble          - load an empty slot (all zero)
//               i_valid/ctrl/rd   - next stage contents
//               o_valid/ctrl/rd   - registered stage contents
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_hold,
    input  wire logic        i_bubble,
    input  wire logic        i_valid,
    input  wire ctrl_t       i_ctrl,
    input  wire logic [4:0]  i_rd,
    output      logic        o_valid,
    output      ctrl_t       o_ctrl,
    output      logic [4:0]  o_rd
);

    logic       r_valid_q, w_valid_d;
    ctrl_t      r_ctrl_q,  w_ctrl_d;
    logic [4:0] r_rd_q,    w_rd_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_ctrl_d  = r_ctrl_q;
        w_rd_d    = r_rd_q;
        if (!i_hold) begin
            if (i_bubble) begin
                w_valid_d = 1'b0;
                w_ctrl_d  = '0;
                w_rd_d    = '0;
            end else begin
                w_valid_d = i_valid;
                w_ctrl_d  = i_ctrl;
                w_rd_d    = i_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_ctrl_q  <= '0;
            r_rd_q    <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_ctrl_q  <= w_ctrl_d;
            r_rd_q    <= w_rd_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_ctrl  = r_ctrl_q;
    assign o_rd    = r_rd_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_seq.sv
`default_nettype none
//==============================================================================
// Module      : pipe_ctrl_seq
// Description : Control sequencer for a 4-stage (ID/EX/MEM/WB) pipeline.
//               Carries decoded control from ID to WB, resolves memory freeze,
//               taken-branch flush and load-use stall, watches for excessive
//               MEM waits and counts hazard events.
// Ports       : clk   - clock
//               reset - synchronous active-high reset
//               bus   - pipe_ctrl_seq_if.slave (ID inputs, branch/memory
//                       status, stage control, hazard and counter outputs)
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_ctrl_seq
    import pipe_ctrl_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    pipe_ctrl_seq_if.slave   bus
);

    // Stage register outputs
    logic       w_ex_valid,  w_mem_valid,  w_wb_valid;
    ctrl_t      w_ex_ctrl,   w_mem_ctrl,   w_wb_ctrl;
    logic [4:0] w_ex_rd,     w_mem_rd,     w_wb_rd;

    // Hazard terms
    logic w_freeze;
    logic w_take;
    logic w_load_use;
    logic w_do_flush;
    logic w_do_lu_stall;

    // Sequencer state
    state_t      r_state_q,      w_state_d;
    logic [7:0]  r_timer_q,      w_timer_d;
    logic        r_timeout_q,    w_timeout_d;
    logic [15:0] r_lu_cnt_q,     w_lu_cnt_d;
    logic [15:0] r_flush_cnt_q,  w_flush_cnt_d;
    logic [15:0] r_wait_cnt_q,   w_wait_cnt_d;

    //--------------------------------------------------------------------------
    // Hazard detection. Only real instructions (valid) can create hazards, so
    // a bubble in EX or MEM never stalls, flushes or counts.
    //--------------------------------------------------------------------------
    assign w_freeze   = w_mem_valid & is_mem_access(w_mem_ctrl) & ~bus.mem_ready;
    assign w_take     = bus.br_taken & w_ex_valid &
                        (w_ex_ctrl.branch | w_ex_ctrl.uncond_br);
    assign w_load_use = bus.id_valid & w_ex_valid & w_ex_ctrl.mem_read &
                        (w_ex_rd != XZR) &
                        ((w_ex_rd == bus.id_rs1) | (w_ex_rd == bus.id_rs2));

    // A freeze overrides everything: the branch stays in EX and is
    // re-evaluated once memory completes.
    assign w_do_flush    = ~w_freeze & w_take;
    assign w_do_lu_stall = ~w_freeze & ~w_take & w_load_use;

    //--------------------------------------------------------------------------
    // Stage registers
    //--------------------------------------------------------------------------
    pipe_stage_reg u_ex_stage (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (w_freeze),
        .i_bubble (w_take | w_load_use),
        .i_valid  (bus.id_valid),
        .i_ctrl   (bus.id_valid ? bus.id_ctrl : ctrl_t'('0)),
        .i_rd     (bus.id_valid ? bus.id_rd   : 5'd0),
        .o_valid  (w_ex_valid),
        .o_ctrl   (w_ex_ctrl),
        .o_rd     (w_ex_rd)
    );

    pipe_stage_reg u_mem_stage (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (w_freeze),
        .i_bubble (1'b0),
        .i_valid  (w_ex_valid),
        .i_ctrl   (w_ex_ctrl),
        .i_rd     (w_ex_rd),
        .o_valid  (w_mem_valid),
        .o_ctrl   (w_mem_ctrl),
        .o_rd     (w_mem_rd)
    );

    pipe_stage_reg u_wb_stage (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (w_freeze),
        .i_bubble (1'b0),
        .i_valid  (w_mem_valid),
        .i_ctrl   (w_mem_ctrl),
        .i_rd     (w_mem_rd),
        .o_valid  (w_wb_valid),
        .o_ctrl   (w_wb_ctrl),
        .o_rd     (w_wb_rd)
    );

    //--------------------------------------------------------------------------
    // MEM wait sequencer: next state, wait timer, sticky timeout, counters
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_timer_d     = r_timer_q;
        w_timeout_d   = r_timeout_q;
        w_lu_cnt_d    = r_lu_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        w_wait_cnt_d  = r_wait_cnt_q;

        case (r_state_q)
            ST_RUN: begin
                if (w_freeze) begin
                    w_state_d = ST_MEM_WAIT;
                    w_timer_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (r_timer_q != TIMEOUT) begin
                    w_timer_d = r_timer_q + 8'd1;
                end
                if (!w_freeze) begin
                    w_state_d = ST_RUN;
                end
            end
            default: begin
                w_state_d = ST_RUN;
            end
        endcase

        // Timeout is flagged on the edge where the timer lands on its limit.
        if ((r_state_q == ST_MEM_WAIT) && (w_timer_d == TIMEOUT)) begin
            w_timeout_d = 1'b1;
        end

        if (w_do_lu_stall) w_lu_cnt_d    = sat_inc16(r_lu_cnt_q);
        if (w_do_flush)    w_flush_cnt_d = sat_inc16(r_flush_cnt_q);
        if (w_freeze)      w_wait_cnt_d  = sat_inc16(r_wait_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_RUN;
            r_timer_q     <= 8'd0;
            r_timeout_q   <= 1'b0;
            r_lu_cnt_q    <= 16'd0;
            r_flush_cnt_q <= 16'd0;
            r_wait_cnt_q  <= 16'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_timer_q     <= w_timer_d;
            r_timeout_q   <= w_timeout_d;
            r_lu_cnt_q    <= w_lu_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
            r_wait_cnt_q  <= w_wait_cnt_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs. Hazard strobes are masked during reset because the stage
    // registers may still hold pre-reset contents in that cycle.
    //--------------------------------------------------------------------------
    assign bus.stall_id     = ~reset & (w_freeze | w_do_lu_stall);
    assign bus.flush_id     = ~reset & w_do_flush;
    assign bus.mem_timeout  = r_timeout_q;
    assign bus.lu_stall_cnt = r_lu_cnt_q;
    assign bus.flush_cnt    = r_flush_cnt_q;
    assign bus.wait_cnt     = r_wait_cnt_q;

    assign bus.ex_valid  = w_ex_valid;
    assign bus.ex_ctrl   = w_ex_ctrl;
    assign bus.ex_rd     = w_ex_rd;
    assign bus.mem_valid = w_mem_valid;
    assign bus.mem_ctrl  = w_mem_ctrl;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.wb_valid  = w_wb_valid;
    assign bus.wb_ctrl   = w_wb_ctrl;
    assign bus.wb_rd     = w_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipe_ctrl_seq
// Description : Directed self-checking bench for pipe_ctrl_seq: reset state,
//               ID-to-WB flow, load-use stall, zero-register exemption,
//               branch flush priority, memory freeze and MEM wait timeout.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipe_ctrl_seq;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pipe_ctrl_seq_if bus ();

    pipe_ctrl_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [7:0] c,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
        bus.id_valid = v;
        bus.id_ctrl  = ctrl_t'(c);
        bus.id_rs1   = rs1;
        bus.id_rs2   = rs2;
        bus.id_rd    = rd;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        bus.br_taken  = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_stall",    32'(bus.stall_id), 32'd0);
        check("rst_flush",    32'(bus.flush_id), 32'd0);
        check("rst_timeout",  32'(bus.mem_timeout), 32'd0);
        check("rst_wait_cnt", 32'(bus.wait_cnt), 32'd0);
        check("rst_state",    32'(dut.r_state_q), 32'(ST_RUN));

        // ID -> EX -> MEM -> WB, one cycle per stage
        reset = 1'b0;
        set_id(1'b1, 8'h11, 5'd1, 5'd2, 5'd3);
        tick();
        check("flow_ex_ctrl", 32'(bus.ex_ctrl), 32'h11);
        check("flow_ex_rd",   32'(bus.ex_rd), 32'd3);
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        tick();
        check("flow_mem_ctrl", 32'(bus.mem_ctrl), 32'h11);
        check("flow_ex_empty", 32'(bus.ex_valid), 32'd0);
        tick();
        check("flow_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("flow_wb_ctrl",  32'(bus.wb_ctrl), 32'h11);
        check("flow_wb_rd",    32'(bus.wb_rd), 32'd3);

        // Load-use: load r5 in EX, ID reads r5
        set_id(1'b1, 8'h0B, 5'd0, 5'd0, 5'd5);
        tick();
        set_id(1'b1, 8'h01, 5'd5, 5'd0, 5'd6);
        #1;
        check("lu_stall",     32'(bus.stall_id), 32'd1);
        check("lu_no_flush",  32'(bus.flush_id), 32'd0);
        tick();
        check("lu_ex_bubble", 32'(bus.ex_valid), 32'd0);
        check("lu_cnt",       32'(bus.lu_stall_cnt), 32'd1);
        check("lu_stall_one", 32'(bus.stall_id), 32'd0);
        tick();
        check("lu_ex_rd",     32'(bus.ex_rd), 32'd6);

        // Load to r31 never stalls
        set_id(1'b1, 8'h0B, 5'd0, 5'd0, 5'd31);
        tick();
        set_id(1'b1, 8'h01, 5'd31, 5'd31, 5'd7);
        #1;
        check("xzr_no_stall", 32'(bus.stall_id), 32'd0);
        tick();
        check("xzr_ex_rd",    32'(bus.ex_rd), 32'd7);
        check("xzr_lu_cnt",   32'(bus.lu_stall_cnt), 32'd1);

        // Taken branch beats simultaneous load-use (EX ctrl = branch+mem_read)
        set_id(1'b1, 8'h22, 5'd0, 5'd0, 5'd8);
        tick();
        set_id(1'b1, 8'h01, 5'd8, 5'd0, 5'd9);
        bus.br_taken = 1'b1;
        #1;
        check("br_flush",     32'(bus.flush_id), 32'd1);
        check("br_no_stall",  32'(bus.stall_id), 32'd0);
        tick();
        check("br_ex_bubble", 32'(bus.ex_valid), 32'd0);
        check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        check("br_lu_cnt",    32'(bus.lu_stall_cnt), 32'd1);
        // br_taken with an empty EX is ignored
        check("br_bubble_noflush", 32'(bus.flush_id), 32'd0);
        bus.br_taken = 1'b0;

        // Memory freeze: store in MEM, mem_ready low for 4 cycles
        set_id(1'b1, 8'h04, 5'd0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 8'h01, 5'd0, 5'd0, 5'd9);
        tick();
        set_id(1'b1, 8'h01, 5'd0, 5'd0, 5'd10);
        bus.mem_ready = 1'b0;
        #1;
        check("frz_no_flush", 32'(bus.flush_id), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("frz_stall_%0d", i), 32'(bus.stall_id), 32'd1);
            tick();
        end
        check("frz_ex_hold",  32'(bus.ex_rd), 32'd9);
        check("frz_mem_hold", 32'(bus.mem_ctrl), 32'h04);
        check("frz_wait_cnt", 32'(bus.wait_cnt), 32'd4);
        check("frz_state",    32'(dut.r_state_q), 32'(ST_MEM_WAIT));
        bus.mem_ready = 1'b1;
        #1;
        check("frz_release",  32'(bus.stall_id), 32'd0);
        tick();
        check("frz_state_run", 32'(dut.r_state_q), 32'(ST_RUN));
        check("frz_wb_ctrl",   32'(bus.wb_ctrl), 32'h04);
        check("frz_mem_rd",    32'(bus.mem_rd), 32'd9);
        check("frz_ex_rd",     32'(bus.ex_rd), 32'd10);

        // Long wait: timeout after 255 MEM_WAIT cycles (256 freeze edges)
        set_id(1'b1, 8'h04, 5'd0, 5'd0, 5'd0);
        tick();
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        tick();
        bus.mem_ready = 1'b0;
        repeat (255) tick();
        check("to_not_yet", 32'(bus.mem_timeout), 32'd0);
        tick();
        check("to_set",     32'(bus.mem_timeout), 32'd1);
        repeat (44) tick();
        check("to_sticky",   32'(bus.mem_timeout), 32'd1);
        check("to_wait_cnt", 32'(bus.wait_cnt), 32'd304);
        check("to_mem_hold", 32'(bus.mem_ctrl), 32'h04);

        // Reset in the middle of the wait
        reset = 1'b1;
        set_id(1'b1, 8'h01, 5'd0, 5'd0, 5'd11);
        #1;
        check("rstw_stall", 32'(bus.stall_id), 32'd0);
        check("rstw_flush", 32'(bus.flush_id), 32'd0);
        tick();
        check("rstw_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rstw_mem_ctrl",  32'(bus.mem_ctrl), 32'd0);
        check("rstw_wb_valid",  32'(bus.wb_valid), 32'd0);
        check("rstw_ex_valid",  32'(bus.ex_valid), 32'd0);
        check("rstw_timeout",   32'(bus.mem_timeout), 32'd0);
        check("rstw_wait_cnt",  32'(bus.wait_cnt), 32'd0);
        check("rstw_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        check("rstw_lu_cnt",    32'(bus.lu_stall_cnt), 32'd0);
        check("rstw_state",     32'(dut.r_state_q), 32'(ST_RUN));
        reset = 1'b0;
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        #1;
        check("post_rst_stall", 32'(bus.stall_id), 32'd0);
        tick();
        check("post_rst_wait_cnt", 32'(bus.wait_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
